mac_tap_seq: RTL and testbench

MAC_TAP_SEQ -- requirements
Module: mac_tap_seq

---
 rtl/mac_tap_seq.sv | 114 +++++++++++
 tb/tb_mac_tap_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_tap_seq.sv
// mac_tap_seq: sequences an external 8-bit MAC through a 1..16 tap FIR.
// Ports:
//   MAC_ACC_CLK, acc_ff_rstn          clock, async active-low reset
//   CFG_WE/CFG_ADDR/CFG_WDATA         coefficient write (IDLE only)
//   CFG_TAP_CNT, CFG_RND              taps-1 and rounding seed, latched per sample
//   SMP_VALID/SMP_DATA/SMP_READY      sample input handshake
//   MAC_OPER_DATA/MAC_COEF_DATA       MAC operands, valid in RUN only
//   EFPGA_MATHB_CLK_EN                MAC accumulator load enable
//   MAC_ACC_CLEAR/MAC_ACC_RND         first-tap feedback select strobes
//   MAC_OUT                           MAC accumulator result
//   RES_VALID/RES_DATA/RES_READY      filter result handshake
//   BUSY                              high outside IDLE
module mac_tap_seq #(
    parameter int MAX_TAPS = 16
) (
    input  logic       MAC_ACC_CLK,
    input  logic       acc_ff_rstn,
    input  logic       CFG_WE,
    input  logic [3:0] CFG_ADDR,
    input  logic [7:0] CFG_WDATA,
    input  logic [3:0] CFG_TAP_CNT,
    input  logic       CFG_RND,
    input  logic       SMP_VALID,
    input  logic [7:0] SMP_DATA,
    output logic       SMP_READY,
    output logic [7:0] MAC_OPER_DATA,
    output logic [7:0] MAC_COEF_DATA,
    output logic       EFPGA_MATHB_CLK_EN,
    output logic       MAC_ACC_CLEAR,
    output logic       MAC_ACC_RND,
    input  logic [7:0] MAC_OUT,
    output logic       RES_VALID,
    output logic [7:0] RES_DATA,
    input  logic       RES_READY,
    output logic       BUSY
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
    state_t     state_q, state_d;
    logic [7:0] coef_q [MAX_TAPS];
    logic [7:0] x_q    [MAX_TAPS];
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q;
    logic       rnd_q;
    logic [7:0] res_data_q;
    logic       res_valid_q;
    logic       accept;
    logic       run;
    logic       first;

    assign accept = SMP_VALID && (state_q == IDLE);
    assign run    = (state_q == RUN);
    assign first  = run && (idx_q == 4'd0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                end
            end
            // The last tap leaves RUN instead of incrementing, so the index
            // never wraps even with all 16 taps.
            RUN:     if (idx_q == cnt_q) state_d = DRAIN; else idx_d = idx_q + 4'd1;
            DRAIN:   state_d = HOLD;
            HOLD:    if (RES_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            rnd_q       <= 1'b0;
            res_data_q  <= 8'd0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < MAX_TAPS; i++) begin
                x_q[i]    <= 8'd0;
                coef_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                x_q[0] <= SMP_DATA;
                for (int i = MAX_TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
                cnt_q <= CFG_TAP_CNT;
                rnd_q <= CFG_RND;
            end
            if (CFG_WE && state_q == IDLE) coef_q[CFG_ADDR] <= CFG_WDATA;
            if (state_q == DRAIN) begin
                res_data_q  <= MAC_OUT;
                res_valid_q <= 1'b1;
            end else if (state_q == HOLD && RES_READY) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // MAC drives are forced to zero outside RUN so the accumulator holds.
    assign MAC_OPER_DATA      = run ? x_q[idx_q] : 8'd0;
    assign MAC_COEF_DATA      = run ? coef_q[idx_q] : 8'd0;
    assign EFPGA_MATHB_CLK_EN = run;
    assign MAC_ACC_CLEAR      = first && !rnd_q;
    assign MAC_ACC_RND        = first && rnd_q;
    assign SMP_READY          = (state_q == IDLE);
    assign BUSY               = (state_q != IDLE);
    assign RES_VALID          = res_valid_q;
    assign RES_DATA           = res_data_q;
endmodule

// File: tb/tb_mac_tap_seq.sv
// tb_mac_tap_seq: directed bench for mac_tap_seq with a behavioural MAC.
module tb_mac_tap_seq;
    logic       MAC_ACC_CLK = 1'b0;
    logic       acc_ff_rstn = 1'b1;
    logic       CFG_WE = 1'b0;
    logic [3:0] CFG_ADDR = 4'd0;
    logic [7:0] CFG_WDATA = 8'd0;
    logic [3:0] CFG_TAP_CNT = 4'd0;
    logic       CFG_RND = 1'b0;
    logic       SMP_VALID = 1'b0;
    logic [7:0] SMP_DATA = 8'd0;
    logic       SMP_READY;
    logic [7:0] MAC_OPER_DATA;
    logic [7:0] MAC_COEF_DATA;
    logic       EFPGA_MATHB_CLK_EN;
    logic       MAC_ACC_CLEAR;
    logic       MAC_ACC_RND;
    logic [7:0] MAC_OUT;
    logic       RES_VALID;
    logic [7:0] RES_DATA;
    logic       RES_READY = 1'b1;
    logic       BUSY;

    int tests = 0;
    int fails = 0;
    logic [7:0] op0, cf0;

    localparam logic [7:0] RND_K = 8'd64;

    mac_tap_seq dut (
        .MAC_ACC_CLK(MAC_ACC_CLK), .acc_ff_rstn(acc_ff_rstn),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA),
        .CFG_TAP_CNT(CFG_TAP_CNT), .CFG_RND(CFG_RND),
        .SMP_VALID(SMP_VALID), .SMP_DATA(SMP_DATA), .SMP_READY(SMP_READY),
        .MAC_OPER_DATA(MAC_OPER_DATA), .MAC_COEF_DATA(MAC_COEF_DATA),
        .EFPGA_MATHB_CLK_EN(EFPGA_MATHB_CLK_EN), .MAC_ACC_CLEAR(MAC_ACC_CLEAR),
        .MAC_ACC_RND(MAC_ACC_RND), .MAC_OUT(MAC_OUT),
        .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_READY(RES_READY),
        .BUSY(BUSY)
    );

    always #5 MAC_ACC_CLK = ~MAC_ACC_CLK;

    // Behavioural MAC: 8-bit accumulator, feedback zeroed or seeded on strobe.
    logic [7:0]  acc = 8'd0;
    logic [15:0] prod;
    logic [7:0]  base;
    assign prod    = MAC_OPER_DATA * MAC_COEF_DATA;
    assign base    = MAC_ACC_CLEAR ? 8'd0 : (MAC_ACC_RND ? RND_K : acc);
    assign MAC_OUT = acc;
    always @(posedge MAC_ACC_CLK) if (EFPGA_MATHB_CLK_EN) acc <= base + prod[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
        CFG_WE = 1'b1; CFG_ADDR = a; CFG_WDATA = d;
        @(posedge MAC_ACC_CLK); #1;
        CFG_WE = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge MAC_ACC_CLK); #1;
        acc_ff_rstn = 1'b0;
        #3 acc_ff_rstn = 1'b1;
    endtask

    // One sample through accept, RUN, DRAIN and HOLD with RES_READY high.
    task automatic do_sample(input string name, input logic [7:0] s, input logic [3:0] cnt,
                             input logic rnd, input logic [7:0] exp);
        int lat, en;
        logic bad_str;
        logic [1:0] str0;
        logic [7:0] res;
        lat = -1; en = 0; bad_str = 1'b0; str0 = 2'b00; res = 8'd0;
        check({name, "_ready"}, 32'(SMP_READY), 32'd1);
        SMP_DATA = s; CFG_TAP_CNT = cnt; CFG_RND = rnd; SMP_VALID = 1'b1; RES_READY = 1'b1;
        @(posedge MAC_ACC_CLK); #1;
        SMP_VALID = 1'b0; CFG_TAP_CNT = ~cnt; CFG_RND = ~rnd; SMP_DATA = 8'hEE;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k == 0) begin
                op0 = MAC_OPER_DATA; cf0 = MAC_COEF_DATA;
                str0 = {MAC_ACC_CLEAR, MAC_ACC_RND};
            end else if (MAC_ACC_CLEAR || MAC_ACC_RND) bad_str = 1'b1;
            if (EFPGA_MATHB_CLK_EN) en++;
            if (RES_VALID) begin
                lat = k; res = RES_DATA;
            end else begin
                @(posedge MAC_ACC_CLK); #1;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(cnt) + 32'd2);
        check({name, "_result"}, 32'(res), 32'(exp));
        check({name, "_clk_en_cycles"}, 32'(en), 32'(cnt) + 32'd1);
        check({name, "_strobe_tap0"}, 32'(str0), rnd ? 32'd1 : 32'd2);
        check({name, "_strobe_later"}, 32'(bad_str), 32'd0);
        if (lat >= 0) begin
            @(posedge MAC_ACC_CLK); #1;
            check({name, "_after_hs"}, 32'({RES_VALID, SMP_READY, BUSY}), 32'b010);
        end
        CFG_TAP_CNT = cnt; CFG_RND = 1'b0;
    endtask

    typedef struct {
        logic [7:0] smp;
        logic [3:0] cnt;
        logic       rnd;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [7];
        logic ok;
        vecs[0] = '{8'd1,  4'd3,  1'b0, 8'd1};
        vecs[1] = '{8'd2,  4'd3,  1'b0, 8'd4};
        vecs[2] = '{8'd3,  4'd3,  1'b0, 8'd10};
        vecs[3] = '{8'd4,  4'd3,  1'b0, 8'd20};
        vecs[4] = '{8'd10, 4'd0,  1'b0, 8'd10};
        vecs[5] = '{8'd0,  4'd1,  1'b1, 8'd84};
        vecs[6] = '{8'd5,  4'd15, 1'b0, 8'd51};

        #1 acc_ff_rstn = 1'b0;
        #11;
        check("reset_outputs", 32'({MAC_OPER_DATA, MAC_COEF_DATA, EFPGA_MATHB_CLK_EN, MAC_ACC_CLEAR,
                                    MAC_ACC_RND, RES_VALID, RES_DATA, BUSY}), 32'd0);
        #10 acc_ff_rstn = 1'b1;
        @(posedge MAC_ACC_CLK); #1;
        check("reset_release_ready", 32'({SMP_READY, BUSY}), 32'b10);

        write_coef(4'd0, 8'd3);
        do_sample("single", 8'd5, 4'd0, 1'b0, 8'd15);
        check("single_oper", 32'(op0), 32'd5);
        check("single_coef", 32'(cf0), 32'd3);

        pulse_reset();
        for (int i = 0; i < 4; i++) write_coef(4'(i), 8'(i + 1));
        for (int i = 0; i < 7; i++) do_sample($sformatf("vec%0d", i), vecs[i].smp, vecs[i].cnt,
                                               vecs[i].rnd, vecs[i].exp);

        SMP_DATA = 8'd6; CFG_TAP_CNT = 4'd0; CFG_RND = 1'b0; SMP_VALID = 1'b1; RES_READY = 1'b0;
        @(posedge MAC_ACC_CLK); #1;
        SMP_VALID = 1'b0;
        for (int k = 0; k < 20 && !RES_VALID; k++) begin
            @(posedge MAC_ACC_CLK); #1;
        end
        check("bp_valid", 32'(RES_VALID), 32'd1);
        check("bp_data", 32'(RES_DATA), 32'd6);
        SMP_VALID = 1'b1; SMP_DATA = 8'd99; CFG_WE = 1'b1; CFG_ADDR = 4'd0; CFG_WDATA = 8'd200;
        ok = 1'b1;
        repeat (10) begin
            @(posedge MAC_ACC_CLK); #1;
            if (!RES_VALID || RES_DATA != 8'd6 || SMP_READY || !BUSY) ok = 1'b0;
        end
        check("bp_stable", 32'(ok), 32'd1);
        SMP_VALID = 1'b0; CFG_WE = 1'b0; RES_READY = 1'b1;
        @(posedge MAC_ACC_CLK); #1;
        check("bp_release", 32'({RES_VALID, SMP_READY}), 32'b01);
        do_sample("bp_follow", 8'd2, 4'd1, 1'b0, 8'd14);

        SMP_DATA = 8'd9; CFG_TAP_CNT = 4'd7; SMP_VALID = 1'b1;
        @(posedge MAC_ACC_CLK); #1;
        SMP_VALID = 1'b0;
        repeat (2) begin
            @(posedge MAC_ACC_CLK); #1;
        end
        check("mid_tap2", 32'({MAC_OPER_DATA, MAC_COEF_DATA}), 32'({8'd6, 8'd3}));
        acc_ff_rstn = 1'b0;
        #2;
        check("mid_reset_outputs", 32'({MAC_OPER_DATA, MAC_COEF_DATA, EFPGA_MATHB_CLK_EN,
                                        MAC_ACC_CLEAR, MAC_ACC_RND, RES_VALID, BUSY}), 32'd0);
        #2 acc_ff_rstn = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(posedge MAC_ACC_CLK); #1;
            if (RES_VALID || BUSY) ok = 1'b0;
        end
        check("mid_no_result", 32'(ok), 32'd1);
        write_coef(4'd0, 8'd1);
        write_coef(4'd1, 8'd1);
        do_sample("post_reset", 8'd7, 4'd1, 1'b0, 8'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
